instr_encode_unit: RTL and testbench
====================================

INSTR_ENCODE_UNIT -- requirements
Module: instr_encode_unit

Interface
REQ-001 SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose `clk_i`, input, 1 bit: clock; all state updates on rising edge.
REQ-003 SHALL expose `rst_ni`, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL expose `valid_i`, input, 1 bit: the field bundle is valid.
REQ-005 SHALL expose `ready_o`, output, 1 bit: the block accepts a bundle this cycle.
REQ-006 SHALL expose `fmt_i`, input, 3 bits: format select; 0=R, 1=I, 2=S, 3=SB, 4=U, 5=UJ; 6 and 7 are illegal.
REQ-007 SHALL expose `opcode_i`, input, 7 bits; `func3_i`, input, 3 bits; `func7_i`, input, 7 bits.
REQ-008 SHALL expose `rs1_i`, `rs2_i` and `rd_i`, inputs, 5 bits each: register indices.
REQ-009 SHALL expose `immed_i`, input, 32 bits: immediate in byte units, as produced by the decode unit.
REQ-010 SHALL expose `instr_o`, output, 32 bits: encoded RV32 instruction.
REQ-011 SHALL expose `valid_o`, output, 1 bit, and `ready_i`, input, 1 bit: output handshake.
REQ-012 SHALL expose `err_o`, output, 1 bit: one-cycle pulse when a bundle is dropped.
REQ-013 SHALL expose `err_cnt_o`, output, 8 bits: saturating count of dropped bundles.
REQ-014 SHALL expose `count_o`, output, 2 bits: output FIFO occupancy (0..2).

Function
REQ-015 SHALL accept a bundle on a rising edge where `valid_i` and `ready_o` are both 1.
REQ-016 SHALL drive `ready_o` = (`count_o` < 2); `ready_o` SHALL depend on registered state only, with no combinational path from `ready_i`.
REQ-017 SHALL encode an R-format bundle as {func7, rs2, rs1, func3, rd, opcode}.
REQ-018 SHALL encode an I-format bundle as {imm[11:0], rs1, func3, rd, opcode}.
REQ-019 SHALL encode an S-format bundle as {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
REQ-020 SHALL encode an SB-format bundle as {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
REQ-021 SHALL encode a U-format bundle as {imm[31:12], rd, opcode}.
REQ-022 SHALL encode a UJ-format bundle as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-023 SHALL ignore immediate bits not listed in REQ-017..REQ-022, with no range check.
REQ-024 SHALL drop an accepted bundle (no FIFO write) when any of the following holds: `fmt_i` is 6 or 7; `opcode_i[1:0]` is not 2'b11; `fmt_i` is SB or UJ and `immed_i[0]` is 1.
REQ-025 SHALL, on each dropped bundle, pulse `err_o` high for exactly the following cycle and increment `err_cnt_o`, saturating at 255.
REQ-026 SHALL write each legal accepted bundle into a 2-entry FIFO of encoded words; the output is taken from the FIFO head.
REQ-027 SHALL drive `valid_o` = (`count_o` != 0) and `instr_o` = FIFO head word.
REQ-028 SHALL give latency 1: a bundle accepted at edge N with the FIFO empty SHALL appear on `instr_o` with `valid_o` = 1 after edge N.
REQ-029 SHALL pop the FIFO head on a rising edge where `valid_o` and `ready_i` are both 1.
REQ-030 SHALL, on a simultaneous push and pop, leave `count_o` unchanged, preserve order and lose no data.
REQ-031 SHALL, on a simultaneous drop and pop, decrement `count_o` by 1.
REQ-032 SHALL hold `instr_o` stable while `valid_o` = 1 and `ready_i` = 0.
REQ-033 SHALL, with the FIFO full and `ready_i` = 0, ignore `valid_i` (no accept, no error).
REQ-034 SHALL implement the FIFO with 1-bit read and write pointers that wrap from 1 to 0.

Reset
REQ-035 SHALL, while `rst_ni` = 0, immediately force: `instr_o` = 0, `valid_o` = 0, `ready_o` = 1, `err_o` = 0, `err_cnt_o` = 0, `count_o` = 0, both pointers = 0.
REQ-036 SHALL discard FIFO contents on reset asserted mid-operation; the first bundle accepted after release SHALL be the only one output.

Verification
REQ-037 SHALL be verified for R/I encoding: fmt=0, func7=0, rs2=2, rs1=1, func3=0, rd=3, op=0x33 -> 0x002081B3; fmt=1, imm=0xFFFFFFFF, rs1=0, func3=0, rd=5, op=0x13 -> 0xFFF00293; each valid 1 cycle after accept.
REQ-038 SHALL be verified for SB/UJ encoding: fmt=3, imm=8, rs1=1, rs2=2, func3=0, op=0x63 -> 0x00208463; fmt=5, imm=16, rd=0, op=0x6F -> 0x0100006F.
REQ-039 SHALL be verified for backpressure: `ready_i` = 0 with 3 consecutive valid bundles -> first two accepted, `count_o` = 2, `ready_o` = 0, third held; `instr_o` stays the first word; raise `ready_i` -> words output in order.
REQ-040 SHALL be verified for streaming: `ready_i` = 1 with back-to-back valid bundles -> one output per cycle, `count_o` stays 1, no bubbles.
REQ-041 SHALL be verified for drop conditions: fmt=6, then op=0x30, then fmt=3 with imm=5 -> three `err_o` pulses, `err_cnt_o` = 3, `valid_o` stays 0; 300 illegal bundles -> `err_cnt_o` = 255.
REQ-042 SHALL be verified for reset mid-operation: FIFO holding 2 words, `rst_ni` pulsed low asynchronously -> all outputs at reset values immediately; next bundle outputs alone.

Source files
------------

// File: rtl/instr_encode_unit.sv
// Instruction encode unit: packs a decoded RV32 field bundle back into a
// 32-bit instruction word and buffers the result in a 2-entry output FIFO.
// Bundles that cannot form a legal instruction are dropped and counted.
module instr_encode_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  func3_i,
  input  logic [6:0]  func7_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] immed_i,
  output logic [31:0] instr_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        err_o,
  output logic [7:0]  err_cnt_o,
  output logic [1:0]  count_o
);

  // Format codes carried on fmt_i; codes 6 and 7 have no encoding.
  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_SB = 3'd3,
    FMT_U  = 3'd4,
    FMT_UJ = 3'd5
  } fmt_e;

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        err_q;
  logic [7:0]  err_cnt;

  logic [31:0] encoded;
  logic        illegal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        drop;

  // Ready and valid come only from the occupancy register, so there is no
  // combinational path from ready_i back to ready_o.
  assign ready_o   = (count < 2'd2);
  assign valid_o   = (count != 2'd0);
  assign instr_o   = mem[rd_ptr];
  assign count_o   = count;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt;

  assign accept = valid_i & ready_o;
  assign push   = accept & ~illegal;
  assign drop   = accept & illegal;
  assign pop    = valid_o & ready_i;

  // Pack the fields into the instruction word; branch and jump immediates
  // are in bytes, so bit 0 is implied and never stored.
  always_comb begin
    encoded = '0;
    case (fmt_i)
      FMT_R:   encoded = {func7_i, rs2_i, rs1_i, func3_i, rd_i, opcode_i};
      FMT_I:   encoded = {immed_i[11:0], rs1_i, func3_i, rd_i, opcode_i};
      FMT_S:   encoded = {immed_i[11:5], rs2_i, rs1_i, func3_i,
                          immed_i[4:0], opcode_i};
      FMT_SB:  encoded = {immed_i[12], immed_i[10:5], rs2_i, rs1_i, func3_i,
                          immed_i[4:1], immed_i[11], opcode_i};
      FMT_U:   encoded = {immed_i[31:12], rd_i, opcode_i};
      FMT_UJ:  encoded = {immed_i[20], immed_i[10:1], immed_i[11],
                          immed_i[19:12], rd_i, opcode_i};
      default: encoded = '0;
    endcase
  end

  // A bundle is unencodable for an unused format code, a non-32-bit opcode,
  // or an odd branch/jump offset that the encoding cannot represent.
  always_comb begin
    illegal = 1'b0;
    if ((fmt_i == 3'd6) || (fmt_i == 3'd7))
      illegal = 1'b1;
    if (opcode_i[1:0] != 2'b11)
      illegal = 1'b1;
    if (((fmt_i == FMT_SB) || (fmt_i == FMT_UJ)) && immed_i[0])
      illegal = 1'b1;
  end

  // Two-entry FIFO with single-bit pointers; occupancy is tracked separately
  // so that full and empty can be told apart when the pointers match.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= encoded;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Error pulse follows each dropped bundle by one cycle; the counter sticks at 255.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q   <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err_q <= drop;
      if (drop && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encode_unit.sv
// Directed testbench for instr_encode_unit with hand-computed encodings.
module tb_instr_encode_unit;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  fmt_i;
  logic [6:0]  opcode_i;
  logic [2:0]  func3_i;
  logic [6:0]  func7_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [4:0]  rd_i;
  logic [31:0] immed_i;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        ready_i;
  logic        err_o;
  logic [7:0]  err_cnt_o;
  logic [1:0]  count_o;

  int checks;
  int fails;

  instr_encode_unit dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .fmt_i     (fmt_i),
    .opcode_i  (opcode_i),
    .func3_i   (func3_i),
    .func7_i   (func7_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .rd_i      (rd_i),
    .immed_i   (immed_i),
    .instr_o   (instr_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o),
    .count_o   (count_o)
  );

  // Free-running 10-unit clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Compare one observed value with its expected value and log a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one field bundle with valid_i high.
  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] op,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] imm);
    fmt_i    = fmt;
    opcode_i = op;
    func3_i  = f3;
    func7_i  = f7;
    rs1_i    = rs1;
    rs2_i    = rs2;
    rd_i     = rd;
    immed_i  = imm;
    valid_i  = 1'b1;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Push one bundle into an empty, non-stalled FIFO and check the encoded word.
  task automatic runSingle(input string tag, input logic [2:0] fmt,
                           input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] imm, input logic [31:0] exp_word);
    ready_i = 1'b1;
    applyStimulus(fmt, op, f3, f7, rs1, rs2, rd, imm);
    tick();
    valid_i = 1'b0;
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd1);
    checkOutput({tag, "_instr"}, instr_o, exp_word);
    checkOutput({tag, "_count"}, 32'(count_o), 32'd1);
    tick();
    checkOutput({tag, "_drain"}, 32'(count_o), 32'd0);
  endtask

  // Directed vectors for every format, handshake corner and reset case.
  initial begin
    checks  = 0;
    fails   = 0;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    fmt_i   = '0;
    opcode_i = '0;
    func3_i = '0;
    func7_i = '0;
    rs1_i   = '0;
    rs2_i   = '0;
    rd_i    = '0;
    immed_i = '0;
    #2;
    checkOutput("rst_instr",   instr_o,          32'd0);
    checkOutput("rst_valid",   32'(valid_o),     32'd0);
    checkOutput("rst_ready",   32'(ready_o),     32'd1);
    checkOutput("rst_err",     32'(err_o),       32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt_o),   32'd0);
    checkOutput("rst_count",   32'(count_o),     32'd0);
    #10;
    rst_ni = 1'b1;
    tick();

    // Encoding of each format.
    runSingle("r_add",  3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0,        32'h002081B3);
    runSingle("i_addi", 3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 32'hFFF00293);
    runSingle("s_sw",   3'd2, 7'h23, 3'd2, 7'd0, 5'd4, 5'd3, 5'd0, 32'h00000ABC, 32'hAA322E23);
    runSingle("sb_beq", 3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8,        32'h00208463);
    runSingle("sb_neg", 3'd3, 7'h63, 3'd1, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 32'hFE001CE3);
    runSingle("u_lui",  3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'h12345FFF, 32'h123453B7);
    runSingle("uj_jal", 3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd16,       32'h0100006F);

    // Backpressure: third bundle is held while the FIFO is full.
    ready_i = 1'b0;
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    checkOutput("bp_count1", 32'(count_o), 32'd1);
    applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF);
    tick();
    checkOutput("bp_count2", 32'(count_o), 32'd2);
    checkOutput("bp_ready0", 32'(ready_o), 32'd0);
    applyStimulus(3'd2, 7'h23, 3'd2, 7'd0, 5'd4, 5'd3, 5'd0, 32'h00000ABC);
    tick();
    checkOutput("bp_held_count", 32'(count_o), 32'd2);
    checkOutput("bp_held_instr", instr_o, 32'h002081B3);
    checkOutput("bp_held_err",   32'(err_o), 32'd0);
    tick();
    checkOutput("bp_stable_instr", instr_o, 32'h002081B3);
    ready_i = 1'b1;
    tick();
    checkOutput("bp_pop1_count", 32'(count_o), 32'd1);
    checkOutput("bp_pop1_instr", instr_o, 32'hFFF00293);
    tick();
    checkOutput("bp_pop2_count", 32'(count_o), 32'd1);
    checkOutput("bp_pop2_instr", instr_o, 32'hAA322E23);
    valid_i = 1'b0;
    tick();
    checkOutput("bp_empty", 32'(valid_o), 32'd0);

    // Streaming: one word per cycle with occupancy pinned at one.
    ready_i = 1'b1;
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    checkOutput("st_w0", instr_o, 32'h002081B3);
    checkOutput("st_c0", 32'(count_o), 32'd1);
    applyStimulus(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'h12345FFF);
    tick();
    checkOutput("st_w1", instr_o, 32'h123453B7);
    checkOutput("st_c1", 32'(count_o), 32'd1);
    applyStimulus(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd16);
    tick();
    checkOutput("st_w2", instr_o, 32'h0100006F);
    checkOutput("st_c2", 32'(count_o), 32'd1);
    checkOutput("st_v2", 32'(valid_o), 32'd1);
    valid_i = 1'b0;
    tick();
    checkOutput("st_drain", 32'(count_o), 32'd0);

    // Drop conditions: bad format, bad opcode, odd branch offset.
    applyStimulus(3'd6, 7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    checkOutput("drop_fmt_err", 32'(err_o), 32'd1);
    checkOutput("drop_fmt_cnt", 32'(err_cnt_o), 32'd1);
    applyStimulus(3'd0, 7'h30, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    checkOutput("drop_op_err", 32'(err_o), 32'd1);
    checkOutput("drop_op_cnt", 32'(err_cnt_o), 32'd2);
    applyStimulus(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5);
    tick();
    checkOutput("drop_odd_err", 32'(err_o), 32'd1);
    checkOutput("drop_odd_cnt", 32'(err_cnt_o), 32'd3);
    checkOutput("drop_valid",   32'(valid_o), 32'd0);
    valid_i = 1'b0;
    tick();
    checkOutput("drop_err_low", 32'(err_o), 32'd0);

    // Drop coinciding with a pop still retires the head word.
    ready_i = 1'b0;
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    checkOutput("dp_count1", 32'(count_o), 32'd1);
    ready_i = 1'b1;
    applyStimulus(3'd7, 7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    checkOutput("dp_count0", 32'(count_o), 32'd0);
    checkOutput("dp_cnt",    32'(err_cnt_o), 32'd4);

    // Saturation of the drop counter.
    for (int i = 0; i < 300; i++) tick();
    valid_i = 1'b0;
    tick();
    checkOutput("sat_cnt", 32'(err_cnt_o), 32'd255);

    // Asynchronous reset with a full FIFO.
    ready_i = 1'b0;
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    tick();
    valid_i = 1'b0;
    checkOutput("mr_full", 32'(count_o), 32'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("mr_instr",   instr_o,        32'd0);
    checkOutput("mr_valid",   32'(valid_o),   32'd0);
    checkOutput("mr_ready",   32'(ready_o),   32'd1);
    checkOutput("mr_err",     32'(err_o),     32'd0);
    checkOutput("mr_err_cnt", 32'(err_cnt_o), 32'd0);
    checkOutput("mr_count",   32'(count_o),   32'd0);
    #3;
    rst_ni = 1'b1;
    tick();
    ready_i = 1'b0;
    applyStimulus(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'h12345FFF);
    tick();
    valid_i = 1'b0;
    checkOutput("mr_next_instr", instr_o, 32'h123453B7);
    checkOutput("mr_next_count", 32'(count_o), 32'd1);
    ready_i = 1'b1;
    tick();
    checkOutput("mr_only_one", 32'(valid_o), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
